seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider.sv | 104 ++++++++++
 2 files changed

// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider.
// The master drives operands and start; the slave returns results and status.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | iterating; counter holds remaining steps
//   DONE  | results valid, done pulse, may accept a new start
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_divider_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic             dz_pend;
  logic             dz_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;

  // Trial subtraction; the top bit of the WIDTH+1 difference is the borrow.
  always_comb begin
    shifted = {rem, work_q[WIDTH-1]};
    diff    = shifted + ~{1'b0, dvs} + {{WIDTH{1'b0}}, 1'b1};
    borrow  = diff[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dvs     <= '0;
      rem     <= '0;
      work_q  <= '0;
      q_r     <= '0;
      r_r     <= '0;
      dz_pend <= 1'b0;
      dz_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= RUN;
            busy_r <= 1'b1;
            dvs    <= bus.divisor;
            // Zero divisor skips iteration: preload the saturated result.
            if (bus.divisor == '0) begin
              dz_pend <= 1'b1;
              cnt     <= '0;
              work_q  <= '1;
              rem     <= bus.dividend;
            end else begin
              dz_pend <= 1'b0;
              cnt     <= CW'(WIDTH);
              work_q  <= bus.dividend;
              rem     <= '0;
            end
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            rem    <= borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            work_q <= {work_q[WIDTH-2:0], ~borrow};
            cnt    <= cnt - CW'(1);
          end else begin
            q_r    <= work_q;
            r_r    <= rem;
            dz_r   <= dz_pend;
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = dz_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
endmodule
